// File: rtl/alu_rs_pkg.sv
// Shared constants for the ALU reservation station: optype codes, widths and sizing defaults.
package alu_rs_pkg;

   localparam int OP_W_DEF     = 6;
   localparam int ROB_ID_W_DEF = 4;
   localparam int DATA_W       = 32;
   localparam int RS_SIZE_DEF  = 16;
   localparam int RS_IDX_W_DEF = $clog2(RS_SIZE_DEF);

   typedef enum logic [OP_W_DEF-1:0] {
      OPTYPE_NOP   = 6'd0,
      OPTYPE_ADD   = 6'd1,
      OPTYPE_SUB   = 6'd2,
      OPTYPE_AND   = 6'd3,
      OPTYPE_OR    = 6'd4,
      OPTYPE_XOR   = 6'd5,
      OPTYPE_SLL   = 6'd6,
      OPTYPE_SRL   = 6'd7,
      OPTYPE_SRA   = 6'd8,
      OPTYPE_SLT   = 6'd9,
      OPTYPE_SLTU  = 6'd10,
      OPTYPE_LUI   = 6'd11,
      OPTYPE_AUIPC = 6'd12,
      OPTYPE_JAL   = 6'd13,
      OPTYPE_JALR  = 6'd14,
      OPTYPE_BEQ   = 6'd15,
      OPTYPE_BNE   = 6'd16,
      OPTYPE_BLT   = 6'd17,
      OPTYPE_BGE   = 6'd18,
      OPTYPE_BLTU  = 6'd19,
      OPTYPE_BGEU  = 6'd20
   } optype_e;

   localparam logic [OP_W_DEF-1:0] NOP = OPTYPE_NOP;

endpackage

// File: rtl/alu_rs_find_first.sv
// Lowest-index priority encoder: reports whether any request bit is set and the index of the first one.
module alu_rs_find_first #(
   parameter int N = 16
) (
   input  logic [N-1:0]         req_i,
   output logic                 found_o,
   output logic [$clog2(N)-1:0] idx_o
);

   localparam int W = $clog2(N);

   // Scanning downward lets the lowest set bit be the last (winning) assignment.
   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            found_o = 1'b1;
            idx_o   = i[W-1:0];
         end
      end
   end

endmodule

// File: rtl/alu_rs.sv
// Reservation station in front of the ALU: buffers issued ops, snoops both CDBs and
// dispatches the lowest-index ready entry per cycle onto registered alu_* outputs.
module alu_rs
   import alu_rs_pkg::*;
#(
   parameter int RS_SIZE  = RS_SIZE_DEF,
   parameter int ROB_ID_W = ROB_ID_W_DEF,
   parameter int OP_W     = OP_W_DEF
) (
   input  logic                clk_in,
   input  logic                rst_n_in,
   input  logic                rdy_in,
   input  logic                clear_in,
   input  logic                issue_valid,
   input  logic [OP_W-1:0]     issue_optype,
   input  logic [ROB_ID_W-1:0] issue_rd_alias,
   input  logic [31:0]         issue_pc,
   input  logic [31:0]         issue_imm,
   input  logic                issue_rs1_busy,
   input  logic                issue_rs2_busy,
   input  logic [ROB_ID_W-1:0] issue_rs1_tag,
   input  logic [ROB_ID_W-1:0] issue_rs2_tag,
   input  logic [31:0]         issue_rs1_val,
   input  logic [31:0]         issue_rs2_val,
   output logic                rs_full,
   input  logic                cdb_alu_valid,
   input  logic                cdb_lsb_valid,
   input  logic [ROB_ID_W-1:0] cdb_alu_tag,
   input  logic [ROB_ID_W-1:0] cdb_lsb_tag,
   input  logic [31:0]         cdb_alu_val,
   input  logic [31:0]         cdb_lsb_val,
   output logic [OP_W-1:0]     alu_optype,
   output logic [ROB_ID_W-1:0] alu_rd_alias,
   output logic [31:0]         alu_pc,
   output logic [31:0]         alu_rs1,
   output logic [31:0]         alu_rs2,
   output logic [31:0]         alu_imm
);

   localparam int IDX_W = $clog2(RS_SIZE);

   logic [RS_SIZE-1:0]  busy_q, p1_q, p2_q;
   logic [OP_W-1:0]     op_q    [RS_SIZE];
   logic [ROB_ID_W-1:0] alias_q [RS_SIZE];
   logic [ROB_ID_W-1:0] t1_q    [RS_SIZE];
   logic [ROB_ID_W-1:0] t2_q    [RS_SIZE];
   logic [31:0]         pc_q    [RS_SIZE];
   logic [31:0]         imm_q   [RS_SIZE];
   logic [31:0]         v1_q    [RS_SIZE];
   logic [31:0]         v2_q    [RS_SIZE];

   logic [OP_W-1:0]     alu_op_q;
   logic [ROB_ID_W-1:0] alu_alias_q;
   logic [31:0]         alu_pc_q, alu_rs1_q, alu_rs2_q, alu_imm_q;

   logic                free_found, rdy_found;
   logic [IDX_W-1:0]    free_idx, rdy_idx;
   logic                in_p1_d, in_p2_d;
   logic [31:0]         in_v1_d, in_v2_d;

   alu_rs_find_first #(.N(RS_SIZE)) u_free (
      .req_i   (~busy_q),
      .found_o (free_found),
      .idx_o   (free_idx)
   );

   alu_rs_find_first #(.N(RS_SIZE)) u_ready (
      .req_i   (busy_q & ~p1_q & ~p2_q),
      .found_o (rdy_found),
      .idx_o   (rdy_idx)
   );

   assign rs_full = &busy_q;

   // Issue-time bypass: a producer broadcasting this cycle resolves the operand immediately.
   always_comb begin
      in_p1_d = issue_rs1_busy;
      in_v1_d = issue_rs1_val;
      in_p2_d = issue_rs2_busy;
      in_v2_d = issue_rs2_val;
      if (issue_rs1_busy && cdb_alu_valid && cdb_alu_tag == issue_rs1_tag) begin
         in_p1_d = 1'b0;
         in_v1_d = cdb_alu_val;
      end else if (issue_rs1_busy && cdb_lsb_valid && cdb_lsb_tag == issue_rs1_tag) begin
         in_p1_d = 1'b0;
         in_v1_d = cdb_lsb_val;
      end
      if (issue_rs2_busy && cdb_alu_valid && cdb_alu_tag == issue_rs2_tag) begin
         in_p2_d = 1'b0;
         in_v2_d = cdb_alu_val;
      end else if (issue_rs2_busy && cdb_lsb_valid && cdb_lsb_tag == issue_rs2_tag) begin
         in_p2_d = 1'b0;
         in_v2_d = cdb_lsb_val;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         busy_q      <= '0;
         p1_q        <= '0;
         p2_q        <= '0;
         for (int i = 0; i < RS_SIZE; i++) begin
            op_q[i]    <= '0;
            alias_q[i] <= '0;
            t1_q[i]    <= '0;
            t2_q[i]    <= '0;
            pc_q[i]    <= '0;
            imm_q[i]   <= '0;
            v1_q[i]    <= '0;
            v2_q[i]    <= '0;
         end
         alu_op_q    <= OP_W'(NOP);
         alu_alias_q <= '0;
         alu_pc_q    <= '0;
         alu_rs1_q   <= '0;
         alu_rs2_q   <= '0;
         alu_imm_q   <= '0;
      end else if (rdy_in) begin
         if (clear_in) begin
            busy_q   <= '0;
            alu_op_q <= OP_W'(NOP);
         end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
               if (busy_q[i] && p1_q[i]) begin
                  if (cdb_alu_valid && cdb_alu_tag == t1_q[i]) begin
                     p1_q[i] <= 1'b0;
                     v1_q[i] <= cdb_alu_val;
                  end else if (cdb_lsb_valid && cdb_lsb_tag == t1_q[i]) begin
                     p1_q[i] <= 1'b0;
                     v1_q[i] <= cdb_lsb_val;
                  end
               end
               if (busy_q[i] && p2_q[i]) begin
                  if (cdb_alu_valid && cdb_alu_tag == t2_q[i]) begin
                     p2_q[i] <= 1'b0;
                     v2_q[i] <= cdb_alu_val;
                  end else if (cdb_lsb_valid && cdb_lsb_tag == t2_q[i]) begin
                     p2_q[i] <= 1'b0;
                     v2_q[i] <= cdb_lsb_val;
                  end
               end
            end

            if (rdy_found) begin
               alu_op_q        <= op_q[rdy_idx];
               alu_alias_q     <= alias_q[rdy_idx];
               alu_pc_q        <= pc_q[rdy_idx];
               alu_rs1_q       <= v1_q[rdy_idx];
               alu_rs2_q       <= v2_q[rdy_idx];
               alu_imm_q       <= imm_q[rdy_idx];
               busy_q[rdy_idx] <= 1'b0;
            end else begin
               alu_op_q <= OP_W'(NOP);
            end

            // Free and ready slots are disjoint, so issue never collides with dispatch.
            if (issue_valid && free_found) begin
               busy_q[free_idx]  <= 1'b1;
               op_q[free_idx]    <= issue_optype;
               alias_q[free_idx] <= issue_rd_alias;
               pc_q[free_idx]    <= issue_pc;
               imm_q[free_idx]   <= issue_imm;
               t1_q[free_idx]    <= issue_rs1_tag;
               t2_q[free_idx]    <= issue_rs2_tag;
               p1_q[free_idx]    <= in_p1_d;
               p2_q[free_idx]    <= in_p2_d;
               v1_q[free_idx]    <= in_v1_d;
               v2_q[free_idx]    <= in_v2_d;
            end
         end
      end
   end

   assign alu_optype   = alu_op_q;
   assign alu_rd_alias = alu_alias_q;
   assign alu_pc       = alu_pc_q;
   assign alu_rs1      = alu_rs1_q;
   assign alu_rs2      = alu_rs2_q;
   assign alu_imm      = alu_imm_q;

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed scenarios plus random traffic against an entry-list model.
module tb_alu_rs;
   import alu_rs_pkg::*;

   localparam int RS = 16;

   logic        clk_in = 1'b0;
   logic        rst_n_in, rdy_in, clear_in, issue_valid;
   logic [5:0]  issue_optype;
   logic [3:0]  issue_rd_alias, issue_rs1_tag, issue_rs2_tag;
   logic [31:0] issue_pc, issue_imm, issue_rs1_val, issue_rs2_val;
   logic        issue_rs1_busy, issue_rs2_busy, rs_full;
   logic        cdb_alu_valid, cdb_lsb_valid;
   logic [3:0]  cdb_alu_tag, cdb_lsb_tag;
   logic [31:0] cdb_alu_val, cdb_lsb_val;
   logic [5:0]  alu_optype;
   logic [3:0]  alu_rd_alias;
   logic [31:0] alu_pc, alu_rs1, alu_rs2, alu_imm;

   always #5 clk_in = ~clk_in;

   alu_rs dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clear_in(clear_in),
      .issue_valid(issue_valid), .issue_optype(issue_optype), .issue_rd_alias(issue_rd_alias),
      .issue_pc(issue_pc), .issue_imm(issue_imm),
      .issue_rs1_busy(issue_rs1_busy), .issue_rs2_busy(issue_rs2_busy),
      .issue_rs1_tag(issue_rs1_tag), .issue_rs2_tag(issue_rs2_tag),
      .issue_rs1_val(issue_rs1_val), .issue_rs2_val(issue_rs2_val),
      .rs_full(rs_full),
      .cdb_alu_valid(cdb_alu_valid), .cdb_lsb_valid(cdb_lsb_valid),
      .cdb_alu_tag(cdb_alu_tag), .cdb_lsb_tag(cdb_lsb_tag),
      .cdb_alu_val(cdb_alu_val), .cdb_lsb_val(cdb_lsb_val),
      .alu_optype(alu_optype), .alu_rd_alias(alu_rd_alias), .alu_pc(alu_pc),
      .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_imm(alu_imm)
   );

   typedef struct {
      bit          busy;
      logic [5:0]  op;
      logic [3:0]  alias_id;
      logic [31:0] pc, imm, v1, v2;
      bit          p1, p2;
      logic [3:0]  t1, t2;
   } ent_t;

   ent_t        m [RS];
   logic [5:0]  exp_op;
   logic [3:0]  exp_alias;
   logic [31:0] exp_pc, exp_rs1, exp_rs2, exp_imm;
   int          n_tests = 0;
   int          n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit m_full();
      for (int i = 0; i < RS; i++) if (!m[i].busy) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit cdb_hit(input logic [3:0] t, output logic [31:0] v);
      v = '0;
      if (cdb_alu_valid && cdb_alu_tag == t) begin v = cdb_alu_val; return 1'b1; end
      if (cdb_lsb_valid && cdb_lsb_tag == t) begin v = cdb_lsb_val; return 1'b1; end
      return 1'b0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < RS; i++) m[i].busy = 1'b0;
      exp_op = NOP; exp_alias = '0;
      exp_pc = '0; exp_rs1 = '0; exp_rs2 = '0; exp_imm = '0;
   endtask

   // One clock of the reservation-station contract, applied to the current inputs.
   task automatic model_step();
      int fi, ri;
      bit hit;
      logic [31:0] v;
      ent_t e;
      if (!rdy_in) return;
      if (clear_in) begin
         for (int i = 0; i < RS; i++) m[i].busy = 1'b0;
         exp_op = NOP;
         return;
      end
      fi = -1; ri = -1;
      for (int i = 0; i < RS; i++) begin
         if (!m[i].busy && fi < 0) fi = i;
         if (m[i].busy && !m[i].p1 && !m[i].p2 && ri < 0) ri = i;
      end
      if (ri >= 0) begin
         exp_op = m[ri].op; exp_alias = m[ri].alias_id; exp_pc = m[ri].pc;
         exp_rs1 = m[ri].v1; exp_rs2 = m[ri].v2; exp_imm = m[ri].imm;
         m[ri].busy = 1'b0;
      end else begin
         exp_op = NOP;
      end
      for (int i = 0; i < RS; i++) begin
         if (m[i].busy && m[i].p1) begin
            hit = cdb_hit(m[i].t1, v);
            if (hit) begin m[i].p1 = 1'b0; m[i].v1 = v; end
         end
         if (m[i].busy && m[i].p2) begin
            hit = cdb_hit(m[i].t2, v);
            if (hit) begin m[i].p2 = 1'b0; m[i].v2 = v; end
         end
      end
      if (issue_valid && fi >= 0) begin
         e.busy = 1'b1; e.op = issue_optype; e.alias_id = issue_rd_alias;
         e.pc = issue_pc; e.imm = issue_imm;
         e.p1 = issue_rs1_busy; e.t1 = issue_rs1_tag; e.v1 = issue_rs1_val;
         e.p2 = issue_rs2_busy; e.t2 = issue_rs2_tag; e.v2 = issue_rs2_val;
         if (e.p1) begin
            hit = cdb_hit(e.t1, v);
            if (hit) begin e.p1 = 1'b0; e.v1 = v; end
         end
         if (e.p2) begin
            hit = cdb_hit(e.t2, v);
            if (hit) begin e.p2 = 1'b0; e.v2 = v; end
         end
         m[fi] = e;
      end
   endtask

   task automatic step();
      check("rs_full", rs_full, m_full());
      model_step();
      @(posedge clk_in); #1;
      check("alu_optype", alu_optype, exp_op);
      if (exp_op != NOP) begin
         check("alu_rd_alias", alu_rd_alias, exp_alias);
         check("alu_pc", alu_pc, exp_pc);
         check("alu_rs1", alu_rs1, exp_rs1);
         check("alu_rs2", alu_rs2, exp_rs2);
         check("alu_imm", alu_imm, exp_imm);
      end
   endtask

   task automatic idle();
      rdy_in = 1'b1; clear_in = 1'b0; issue_valid = 1'b0;
      issue_rs1_busy = 1'b0; issue_rs2_busy = 1'b0;
      cdb_alu_valid = 1'b0; cdb_lsb_valid = 1'b0;
   endtask

   task automatic set_issue(input logic [5:0] op, input logic [3:0] al,
                            input bit b1, input logic [3:0] t1, input logic [31:0] v1,
                            input bit b2, input logic [3:0] t2, input logic [31:0] v2);
      issue_valid = 1'b1; issue_optype = op; issue_rd_alias = al;
      issue_pc = $urandom; issue_imm = $urandom;
      issue_rs1_busy = b1; issue_rs1_tag = t1; issue_rs1_val = v1;
      issue_rs2_busy = b2; issue_rs2_tag = t2; issue_rs2_val = v2;
   endtask

   task automatic set_cdb(input bit alu, input logic [3:0] t, input logic [31:0] v);
      if (alu) begin cdb_alu_valid = 1'b1; cdb_alu_tag = t; cdb_alu_val = v; end
      else     begin cdb_lsb_valid = 1'b1; cdb_lsb_tag = t; cdb_lsb_val = v; end
   endtask

   task automatic drain(input int n);
      idle();
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      rst_n_in = 1'b0;
      idle();
      issue_optype = '0; issue_rd_alias = '0; issue_pc = '0; issue_imm = '0;
      issue_rs1_tag = '0; issue_rs2_tag = '0; issue_rs1_val = '0; issue_rs2_val = '0;
      cdb_alu_tag = '0; cdb_lsb_tag = '0; cdb_alu_val = '0; cdb_lsb_val = '0;
      model_reset();
      #12;
      check("reset_optype", alu_optype, NOP);
      check("reset_full", rs_full, 1'b0);
      check("reset_alias", alu_rd_alias, 4'd0);
      check("reset_pc", alu_pc, 32'd0);
      check("reset_rs1", alu_rs1, 32'd0);
      check("reset_rs2", alu_rs2, 32'd0);
      check("reset_imm", alu_imm, 32'd0);
      rst_n_in = 1'b1;
      @(posedge clk_in); #1;

      // Fully ready ADD: visible one edge after issue, then NOP.
      set_issue(OPTYPE_ADD, 4'd3, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd7);
      step();
      idle(); step();
      check("add_op", alu_optype, OPTYPE_ADD);
      check("add_rs1", alu_rs1, 32'd5);
      check("add_rs2", alu_rs2, 32'd7);
      check("add_alias", alu_rd_alias, 4'd3);
      step();
      check("add_then_nop", alu_optype, NOP);

      // SUB waiting on the LSB CDB.
      set_issue(OPTYPE_SUB, 4'd4, 1'b1, 4'd2, 32'd0, 1'b0, 4'd0, 32'd3);
      step();
      idle(); step();
      set_cdb(1'b0, 4'd2, 32'h100); step();
      idle(); step();
      check("sub_op", alu_optype, OPTYPE_SUB);
      check("sub_rs1", alu_rs1, 32'h100);

      // Issue-time bypass from the ALU CDB.
      set_issue(OPTYPE_XOR, 4'd7, 1'b0, 4'd0, 32'd1, 1'b1, 4'd6, 32'd0);
      set_cdb(1'b1, 4'd6, 32'd9);
      step();
      idle(); step();
      check("bypass_op", alu_optype, OPTYPE_XOR);
      check("bypass_rs2", alu_rs2, 32'd9);
      drain(2);

      // Fill all entries on tag 1, then release in index order.
      for (int i = 0; i < RS; i++) begin
         set_issue(OPTYPE_OR, 4'(i), 1'b1, 4'd1, 32'd0, 1'b0, 4'd0, 32'(i));
         step();
      end
      idle();
      check("full16", rs_full, 1'b1);
      set_cdb(1'b1, 4'd1, 32'h11); step();
      idle();
      for (int i = 0; i < RS; i++) begin
         step();
         check("fill_order_alias", alu_rd_alias, 32'(i));
         if (i == 0) check("full_drop", rs_full, 1'b0);
      end
      drain(2);

      // Flush with a colliding issue.
      for (int i = 0; i < 5; i++) begin
         set_issue(OPTYPE_AND, 4'(i), 1'b1, 4'd9, 32'd0, 1'b0, 4'd0, 32'd1);
         step();
      end
      set_issue(OPTYPE_ADD, 4'd12, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd2);
      clear_in = 1'b1;
      step();
      idle();
      check("clear_full", rs_full, 1'b0);
      check("clear_op", alu_optype, NOP);
      set_cdb(1'b1, 4'd9, 32'h99); step();
      drain(3);

      // Freeze with a ready entry and an active CDB.
      set_issue(OPTYPE_SLT, 4'd8, 1'b1, 4'd5, 32'd0, 1'b0, 4'd0, 32'd2);
      step();
      set_issue(OPTYPE_ADD, 4'd9, 1'b0, 4'd0, 32'd10, 1'b0, 4'd0, 32'd20);
      step();
      idle();
      rdy_in = 1'b0;
      set_cdb(1'b1, 4'd5, 32'hDEAD);
      set_issue(OPTYPE_SUB, 4'd10, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd1);
      for (int i = 0; i < 3; i++) begin
         step();
         check("freeze_op", alu_optype, NOP);
      end
      idle(); step();
      check("unfreeze_op", alu_optype, OPTYPE_ADD);
      step();
      check("ignored_cdb", alu_optype, NOP);
      set_cdb(1'b0, 4'd5, 32'h55); step();
      idle(); step();
      check("late_wake_rs1", alu_rs1, 32'h55);
      drain(2);

      // Random traffic.
      for (int c = 0; c < 3000; c++) begin
         idle();
         rdy_in   = ($urandom_range(9) != 0);
         clear_in = ($urandom_range(49) == 0);
         if (!m_full() && $urandom_range(9) < 6)
            set_issue(6'($urandom_range(20, 1)), 4'($urandom), $urandom_range(9) < 4, 4'($urandom),
                      $urandom, $urandom_range(9) < 4, 4'($urandom), $urandom);
         if ($urandom_range(9) < 6) set_cdb(1'b1, 4'($urandom), $urandom);
         if ($urandom_range(9) < 6) set_cdb(1'b0, 4'($urandom), $urandom);
         if (c == 1500) begin
            idle();
            #3 rst_n_in = 1'b0;
            #1;
            model_reset();
            check("async_reset_op", alu_optype, NOP);
            check("async_reset_full", rs_full, 1'b0);
            #2 rst_n_in = 1'b1;
         end
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
